// File: rtl/rf_phoenix_vec_serializer_if.sv
// Purpose : Bundles the vector-in and beat-out handshakes of
//           rf_phoenix_vec_serializer.
// Signals : in_valid/in_ready/in_vec/in_mask/in_tag  - vector offer side
//           out_valid/out_ready/out_data/out_lane/out_tag/out_last - beat side
// Modports: slave  - serializer view (consumes vectors, produces beats)
//           master - environment view (produces vectors, consumes beats)
interface rf_phoenix_vec_serializer_if #(
    parameter int unsigned NLANES = 16,
    parameter int unsigned TAGW   = 6
);
    localparam int unsigned LANEW = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int unsigned VECW  = NLANES * 32;

    logic              in_valid;
    logic              in_ready;
    logic [VECW-1:0]   in_vec;
    logic [NLANES-1:0] in_mask;
    logic [TAGW-1:0]   in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic [LANEW-1:0]  out_lane;
    logic [TAGW-1:0]   out_tag;
    logic              out_last;

    modport slave (
        input  in_valid, in_vec, in_mask, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_tag, out_last
    );

    modport master (
        output in_valid, in_vec, in_mask, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_tag, out_last
    );
endinterface

// File: rtl/rf_phoenix_vec_serializer.sv
// Purpose : Accepts an NLANES x 32-bit vector with a lane-enable mask and tag,
//           and emits the enabled lanes one beat at a time in ascending lane
//           order. A zero mask completes immediately with no beats.
// Ports   : clk, rst_n   - clock, asynchronous active-low reset
//           flush        - synchronous abort of the vector in progress
//           sif          - handshake bundle (slave modport)
//           done         - one-cycle pulse when a vector completes
//           busy         - a vector is held (state RUN)
//           beat_count   - saturating count of beat handshakes, present only
//                          when RFPHOENIX_VSER_BEATCNT_EN is defined
// Config  : `define RFPHOENIX_VSER_BEATCNT_EN adds the beat_count output.
// Note    : in_ready (sif.in_ready) is combinational; every other output is
//           registered.
module rf_phoenix_vec_serializer #(
    parameter int unsigned NLANES = 16,
    parameter int unsigned TAGW   = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    rf_phoenix_vec_serializer_if.slave sif,
    output logic                       done,
    output logic                       busy
`ifdef RFPHOENIX_VSER_BEATCNT_EN
    ,
    output logic [31:0]                beat_count
`endif
);

    localparam int unsigned LANEW = (NLANES > 1) ? $clog2(NLANES) : 1;
    localparam int unsigned VECW  = NLANES * 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [VECW-1:0]   vec_q;
    logic [VECW-1:0]   vec_d;
    logic [NLANES-1:0] rem_q;
    logic [NLANES-1:0] rem_d;
    logic [TAGW-1:0]   tag_q;
    logic [TAGW-1:0]   tag_d;

    logic              in_ready_c;
    logic              accept;
    logic              hs;
    logic              hs_last;

    logic              out_valid_d;
    logic              out_last_d;
    logic [31:0]       out_data_d;
    logic [LANEW-1:0]  out_lane_d;
    logic              done_d;
    logic              found;

    // Flush overrides both the beat handshake and any new accept.
    assign hs         = sif.out_valid && sif.out_ready && !flush;
    assign hs_last    = hs && sif.out_last;
    assign in_ready_c = !flush && ((state_q == IDLE) || hs_last);
    assign accept     = sif.in_valid && in_ready_c;
    assign sif.in_ready = in_ready_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = (sif.in_mask != '0) ? RUN : IDLE;
                    end
                end
                RUN: begin
                    if (hs_last) begin
                        // Reloading on the last beat keeps beats back to back.
                        if (accept && (sif.in_mask != '0)) begin
                            state_d = RUN;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Next held vector, remaining mask, and the beat to present next cycle.
    always_comb begin
        vec_d       = vec_q;
        rem_d       = rem_q;
        tag_d       = tag_q;
        done_d      = 1'b0;
        out_lane_d  = '0;
        out_data_d  = '0;
        found       = 1'b0;

        if (flush) begin
            rem_d = '0;
        end else if (accept) begin
            vec_d  = sif.in_vec;
            rem_d  = sif.in_mask;
            tag_d  = sif.in_tag;
            done_d = hs_last || (sif.in_mask == '0);
        end else if (hs) begin
            // Clear the lowest set bit: that is the lane just handed over.
            rem_d  = rem_q & (rem_q - NLANES'(1));
            done_d = sif.out_last;
        end

        for (int g = 0; g < int'(NLANES); g++) begin
            if (rem_d[g] && !found) begin
                found      = 1'b1;
                out_lane_d = LANEW'(g);
                out_data_d = vec_d[g*32 +: 32];
            end
        end

        out_valid_d = (state_d == RUN);
        out_last_d  = (rem_d != '0) && ((rem_d & (rem_d - NLANES'(1))) == '0);
    end

    // Datapath and registered outputs; beat fields hold while no beat is shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q         <= '0;
            rem_q         <= '0;
            tag_q         <= '0;
            sif.out_valid <= 1'b0;
            sif.out_last  <= 1'b0;
            sif.out_data  <= '0;
            sif.out_lane  <= '0;
            sif.out_tag   <= '0;
            done          <= 1'b0;
            busy          <= 1'b0;
        end else begin
            vec_q         <= vec_d;
            rem_q         <= rem_d;
            tag_q         <= tag_d;
            sif.out_valid <= out_valid_d;
            sif.out_last  <= out_last_d;
            done          <= done_d;
            busy          <= (state_d == RUN);
            if (out_valid_d) begin
                sif.out_data <= out_data_d;
                sif.out_lane <= out_lane_d;
                sif.out_tag  <= tag_d;
            end
        end
    end

`ifdef RFPHOENIX_VSER_BEATCNT_EN
    // Saturating count of completed beat handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count <= '0;
        end else if (hs && (beat_count != 32'hFFFF_FFFF)) begin
            beat_count <= beat_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_phoenix_vec_serializer.sv
// Directed bench for rf_phoenix_vec_serializer (NLANES=16, TAGW=6).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_rf_phoenix_vec_serializer;

    localparam int unsigned NLANES = 16;
    localparam int unsigned TAGW   = 6;

    logic clk;
    logic rst_n;
    logic flush;
    logic done;
    logic busy;
`ifdef RFPHOENIX_VSER_BEATCNT_EN
    logic [31:0] beat_count;
`endif

    int checks;
    int errors;

    rf_phoenix_vec_serializer_if #(.NLANES(NLANES), .TAGW(TAGW)) vif ();

    rf_phoenix_vec_serializer #(.NLANES(NLANES), .TAGW(TAGW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .sif        (vif),
        .done       (done),
        .busy       (busy)
`ifdef RFPHOENIX_VSER_BEATCNT_EN
        ,
        .beat_count (beat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        flush        = 1'b0;
        vif.in_valid = 1'b0;
        vif.in_mask  = '0;
        vif.in_tag   = '0;
        vif.out_ready = 1'b1;
        for (int g = 0; g < int'(NLANES); g++) vif.in_vec[g*32 +: 32] = 32'(100 + g);
        step();
        step();
        checks++;
        if (vif.out_valid !== 1'b0 || vif.out_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b last=%b done=%b busy=%b required all 0",
                     vif.out_valid, vif.out_last, done, busy);
        end
        checks++;
        if (vif.out_data !== 32'd0 || vif.out_lane !== 4'd0 || vif.out_tag !== 6'd0) begin
            errors++;
            $display("FAIL reset_data: data=%0d lane=%0d tag=%0d required 0",
                     vif.out_data, vif.out_lane, vif.out_tag);
        end
`ifdef RFPHOENIX_VSER_BEATCNT_EN
        checks++;
        if (beat_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_beat_count: got %0d required 0", beat_count);
        end
`endif
        rst_n = 1'b1;
        #1;
        checks++;
        if (vif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", vif.in_ready);
        end
    endtask

    task automatic test_ascending();
        int lanes [4] = '{0, 5, 10, 15};
        vif.in_valid = 1'b1;
        vif.in_mask  = 16'h8421;
        vif.in_tag   = 6'd5;
        vif.out_ready = 1'b1;
        step();
        vif.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (vif.out_valid !== 1'b1 || vif.out_lane !== 4'(lanes[i]) ||
                vif.out_data !== 32'(100 + lanes[i]) || vif.out_tag !== 6'd5 ||
                vif.out_last !== (i == 3) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL asc_beat%0d: valid=%b lane=%0d data=%0d tag=%0d last=%b busy=%b done=%b required 1 %0d %0d 5 %b 1 0",
                         i, vif.out_valid, vif.out_lane, vif.out_data, vif.out_tag, vif.out_last,
                         busy, done, lanes[i], 100 + lanes[i], (i == 3));
            end
            step();
        end
        checks++;
        if (vif.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL asc_done: valid=%b done=%b busy=%b required 0 1 0", vif.out_valid, done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL asc_done_pulse: done=%b required 0", done);
        end
    endtask

    task automatic test_stall();
        vif.in_valid  = 1'b1;
        vif.in_mask   = 16'h0003;
        vif.in_tag    = 6'd9;
        vif.out_ready = 1'b0;
        step();
        vif.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vif.out_valid !== 1'b1 || vif.out_lane !== 4'd0 || vif.out_data !== 32'd100 ||
                vif.out_last !== 1'b0 || vif.out_tag !== 6'd9 || vif.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: valid=%b lane=%0d data=%0d last=%b tag=%0d in_ready=%b required 1 0 100 0 9 0",
                         i, vif.out_valid, vif.out_lane, vif.out_data, vif.out_last, vif.out_tag, vif.in_ready);
            end
            if (i < 2) step();
        end
        vif.out_ready = 1'b1;
        step();
        checks++;
        if (vif.out_valid !== 1'b1 || vif.out_lane !== 4'd1 || vif.out_data !== 32'd101 || vif.out_last !== 1'b1) begin
            errors++;
            $display("FAIL stall_beat1: valid=%b lane=%0d data=%0d last=%b required 1 1 101 1",
                     vif.out_valid, vif.out_lane, vif.out_data, vif.out_last);
        end
        step();
        checks++;
        if (vif.out_valid !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: valid=%b done=%b required 0 1", vif.out_valid, done);
        end
        step();
    endtask

    task automatic test_beat_count();
`ifdef RFPHOENIX_VSER_BEATCNT_EN
        checks++;
        if (beat_count !== 32'd6) begin
            errors++;
            $display("FAIL beat_count: got %0d required 6", beat_count);
        end
`endif
    endtask

    task automatic test_zero_mask();
        vif.in_valid = 1'b1;
        vif.in_mask  = 16'h0000;
        #1;
        checks++;
        if (vif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_in_ready_pre: got %b required 1", vif.in_ready);
        end
        step();
        vif.in_valid = 1'b0;
        #1;
        checks++;
        if (vif.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || vif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: valid=%b done=%b busy=%b in_ready=%b required 0 1 0 1",
                     vif.out_valid, done, busy, vif.in_ready);
        end
        step();
        checks++;
        if (done !== 1'b0 || vif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_after: done=%b valid=%b required 0 0", done, vif.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        vif.out_ready = 1'b1;
        vif.in_valid  = 1'b1;
        vif.in_mask   = 16'h0001;
        vif.in_tag    = 6'd1;
        step();
        vif.in_mask = 16'h0002;
        vif.in_tag  = 6'd2;
        #1;
        checks++;
        if (vif.out_valid !== 1'b1 || vif.out_lane !== 4'd0 || vif.out_last !== 1'b1 || vif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: valid=%b lane=%0d last=%b in_ready=%b required 1 0 1 1",
                     vif.out_valid, vif.out_lane, vif.out_last, vif.in_ready);
        end
        step();
        vif.in_valid = 1'b0;
        checks++;
        if (vif.out_valid !== 1'b1 || vif.out_lane !== 4'd1 || vif.out_data !== 32'd101 ||
            vif.out_tag !== 6'd2 || vif.out_last !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second: valid=%b lane=%0d data=%0d tag=%0d last=%b done=%b required 1 1 101 2 1 1",
                     vif.out_valid, vif.out_lane, vif.out_data, vif.out_tag, vif.out_last, done);
        end
        step();
        checks++;
        if (vif.out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: valid=%b done=%b busy=%b required 0 1 0", vif.out_valid, done, busy);
        end
        step();
    endtask

    task automatic test_flush();
        vif.out_ready = 1'b1;
        vif.in_valid  = 1'b1;
        vif.in_mask   = 16'hFFFF;
        vif.in_tag    = 6'd3;
        step();
        vif.in_valid = 1'b0;
        step();
        checks++;
        if (vif.out_valid !== 1'b1 || vif.out_lane !== 4'd1) begin
            errors++;
            $display("FAIL flush_beat2: valid=%b lane=%0d required 1 1", vif.out_valid, vif.out_lane);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (vif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready_low: got %b required 0", vif.in_ready);
        end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (vif.out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || vif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_after: valid=%b done=%b busy=%b in_ready=%b required 0 0 0 1",
                     vif.out_valid, done, busy, vif.in_ready);
        end
        step();
        checks++;
        if (done !== 1'b0 || vif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_done: done=%b valid=%b required 0 0", done, vif.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        vif.out_ready = 1'b1;
        vif.in_valid  = 1'b1;
        vif.in_mask   = 16'hFFFF;
        vif.in_tag    = 6'h2A;
        step();
        vif.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if (vif.out_valid !== 1'b0 || vif.out_last !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
            vif.out_data !== 32'd0 || vif.out_lane !== 4'd0 || vif.out_tag !== 6'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b last=%b done=%b busy=%b data=%0d lane=%0d tag=%0d required all 0",
                     vif.out_valid, vif.out_last, done, busy, vif.out_data, vif.out_lane, vif.out_tag);
        end
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (vif.out_valid !== 1'b0 || busy !== 1'b0 || vif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: valid=%b busy=%b in_ready=%b required 0 0 1",
                     vif.out_valid, busy, vif.in_ready);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_ascending();
        test_stall();
        test_beat_count();
        test_zero_mask();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
